// File: rtl/binning_pkg.sv
// Shared types and width helpers for the K x K binning datapath and its sequencer.
package binning_pkg;

    // Sequencer states: waiting for start of frame, filling a band, last row of a band
    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_FILL     = 2'd1,
        S_LAST     = 2'd2
    } sched_state_t;

    // Legal bin edge range (power of two)
    localparam int MIN_KERNEL = 2;
    localparam int MAX_KERNEL = 16;

    // log2 of the bin edge; K is a power of two so this is exact
    function automatic int log2k(input int k);
        return $clog2(k);
    endfunction

    // Bits needed to carry a coordinate in 0..res-1
    function automatic int coord_w(input int res);
        return (res > 1) ? $clog2(res) : 1;
    endfunction

    // Bits needed to carry a binned coordinate (coordinate >> log2K)
    function automatic int bin_w(input int res, input int k);
        return coord_w(res) - log2k(k);
    endfunction

endpackage

// File: rtl/binning_sync_check.sv
// Stream continuity checker: remembers the last accepted beat and flags whether
// the current beat is its raster successor, a start of frame, or the final beat.
module binning_sync_check
    import binning_pkg::*;
#(
    parameter int HRES = 1280,
    parameter int VRES = 720
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [coord_w(HRES)-1:0] hcount,
    input  logic [coord_w(VRES)-1:0] vcount,
    input  logic                     accept,
    output logic                     expected,
    output logic                     sof,
    output logic                     eof
);
    localparam int HW  = coord_w(HRES);
    localparam int VW  = coord_w(VRES);
    localparam int HW1 = HW + 1;
    localparam int VW1 = VW + 1;

    logic [HW-1:0] prev_h;
    logic [VW-1:0] prev_v;
    logic [HW:0]   h_inc;
    logic [VW:0]   v_inc;

    // Capture coordinates of every beat the sequencer accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_h <= '0;
            prev_v <= '0;
        end else if (accept) begin
            prev_h <= hcount;
            prev_v <= vcount;
        end
    end

    // One extra bit so the increment never wraps into a false match
    assign h_inc = {1'b0, prev_h} + HW1'(1);
    assign v_inc = {1'b0, prev_v} + VW1'(1);

    assign expected = ((vcount == prev_v) && ({1'b0, hcount} == h_inc)) ||
                      ((hcount == '0) && ({1'b0, vcount} == v_inc) &&
                       (prev_h == HW'(HRES - 1)));
    assign sof      = (hcount == '0) && (vcount == '0);
    assign eof      = (hcount == HW'(HRES - 1)) && (vcount == VW'(VRES - 1));

endmodule

// File: rtl/binning_sched.sv
// Control sequencer for the K x K binning datapath: line-buffer write select,
// accumulate/emit strobes, bin coordinates, frame-done and sync-error pulses.
// Optional BINNING_SCHED_STATS_EN adds saturating frame and error counters.
module binning_sched
    import binning_pkg::*;
#(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int KERNEL_SIZE = 4
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic [coord_w(HRES)-1:0]             hcount_in,
    input  logic [coord_w(VRES)-1:0]             vcount_in,
    input  logic                                 data_valid_in,
    output logic [KERNEL_SIZE-1:0]               wr_sel_out,
    output logic                                 acc_en_out,
    output logic                                 emit_out,
    output logic [bin_w(HRES, KERNEL_SIZE)-1:0]  bin_hcount_out,
    output logic [bin_w(VRES, KERNEL_SIZE)-1:0]  bin_vcount_out,
    output logic                                 frame_done_out,
    output logic                                 sync_err_out
`ifdef BINNING_SCHED_STATS_EN
    ,
    output logic [15:0]                          frame_count_out,
    output logic [15:0]                          err_count_out
`endif
);
    localparam int HW         = coord_w(HRES);
    localparam int LK         = log2k(KERNEL_SIZE);
    localparam int BHW        = bin_w(HRES, KERNEL_SIZE);
    localparam int BVW        = bin_w(VRES, KERNEL_SIZE);
    localparam int FULL_COLS  = HRES / KERNEL_SIZE;
    localparam int FULL_BANDS = VRES / KERNEL_SIZE;

    logic [1:0]             rst_sync;
    logic                   rst_n;
    sched_state_t           state, state_nx;
    logic [LK-1:0]          row_idx, row_nx;
    logic [BVW-1:0]         band, band_nx;
    logic                   accept, expected, sof, eof;
    logic [KERNEL_SIZE-1:0] wr_sel_nx;
    logic                   acc_nx, emit_nx, done_nx, err_nx;

    // Reset asserts immediately, releases two clocks after rst_n_in rises
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    binning_sync_check #(.HRES(HRES), .VRES(VRES)) u_sync (
        .clk      (clk_in),
        .rst_n    (rst_n),
        .hcount   (hcount_in),
        .vcount   (vcount_in),
        .accept   (accept),
        .expected (expected),
        .sof      (sof),
        .eof      (eof)
    );

    // State and band/row counters
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_WAIT_SOF;
            row_idx <= '0;
            band    <= '0;
        end else begin
            state   <= state_nx;
            row_idx <= row_nx;
            band    <= band_nx;
        end
    end

    // Next state and next output values for the current beat
    always_comb begin
        state_nx  = state;
        row_nx    = row_idx;
        band_nx   = band;
        accept    = 1'b0;
        wr_sel_nx = '0;
        acc_nx    = 1'b0;
        emit_nx   = 1'b0;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        if (data_valid_in) begin
            if (state != S_WAIT_SOF && expected) begin
                accept = 1'b1;
                // A continuous beat at column 0 is always a row change
                if (hcount_in == '0) begin
                    row_nx = row_idx + LK'(1);
                    if (row_nx == '0) begin
                        band_nx  = band + BVW'(1);
                        state_nx = S_FILL;
                    end else if (row_nx == LK'(KERNEL_SIZE - 1)) begin
                        state_nx = S_LAST;
                    end
                end
            end else begin
                // Out-of-order beat while active is an error; an SOF always restarts
                err_nx   = (state != S_WAIT_SOF);
                state_nx = S_WAIT_SOF;
                if (sof) begin
                    accept   = 1'b1;
                    row_nx   = '0;
                    band_nx  = '0;
                    state_nx = S_FILL;
                end
            end
            if (accept) begin
                wr_sel_nx = KERNEL_SIZE'(1) << row_nx;
                acc_nx    = (state_nx == S_LAST);
                // Only complete bins emit: skip trailing partial columns and bands
                emit_nx   = acc_nx &&
                            (hcount_in[LK-1:0] == LK'(KERNEL_SIZE - 1)) &&
                            (int'(hcount_in[HW-1:LK]) < FULL_COLS) &&
                            (int'(band_nx) < FULL_BANDS);
                if (eof && !sof) begin
                    done_nx  = 1'b1;
                    state_nx = S_WAIT_SOF;
                end
            end
        end
    end

    // Registered outputs; bin coordinates hold between accepted beats
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_out     <= '0;
            acc_en_out     <= 1'b0;
            emit_out       <= 1'b0;
            frame_done_out <= 1'b0;
            sync_err_out   <= 1'b0;
            bin_hcount_out <= '0;
            bin_vcount_out <= '0;
        end else begin
            wr_sel_out     <= wr_sel_nx;
            acc_en_out     <= acc_nx;
            emit_out       <= emit_nx;
            frame_done_out <= done_nx;
            sync_err_out   <= err_nx;
            if (accept) begin
                bin_hcount_out <= hcount_in[HW-1:LK];
                bin_vcount_out <= band_nx;
            end
        end
    end

`ifdef BINNING_SCHED_STATS_EN
    // Saturating frame and error counters
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_out <= '0;
            err_count_out   <= '0;
        end else begin
            if (done_nx && frame_count_out != 16'hFFFF) frame_count_out <= frame_count_out + 16'd1;
            if (err_nx && err_count_out != 16'hFFFF)   err_count_out   <= err_count_out + 16'd1;
        end
    end
`endif

endmodule

// File: doc/binning_sched.md
# binning_sched

Control-plane sequencer for the K×K binning datapath. It watches the raw pixel coordinate stream and drives the rest of the datapath:
- the one-hot write-select for the K line-buffer BRAMs;
- the accumulate enable and emit strobe for the popcount/threshold stage;
- the binned output coordinates, frame-done and sync-error pulses.

It replaces the ad-hoc row-rotation and vcount-shift logic inside the binning datapath. All control is cycle-registered and checks stream continuity.

## Interface
- HRES, 1280, active pixels per row
- VRES, 720, active rows per frame
- KERNEL_SIZE, 4, bin edge K; power of two, 2..16
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; asynchronous, active-low
- hcount_in  input  $clog2(HRES)  column of current beat
- vcount_in  input  $clog2(VRES)  row of current beat
- data_valid_in  input  1  beat qualifier; gaps allowed anywhere
- wr_sel_out  output  KERNEL_SIZE  one-hot line-buffer write enable
- acc_en_out  output  1  beat is in last row of a band; accumulate it
- emit_out  output  1  last beat of a K×K bin; threshold and emit
- bin_hcount_out  output  $clog2(HRES)-$clog2(K)  bin column (hcount_in>>log2K)
- bin_vcount_out  output  $clog2(VRES)-$clog2(K)  bin row (band index)
- frame_done_out  output  1  pulse on beat (HRES-1, VRES-1)
- sync_err_out  output  1  pulse on continuity violation

## Operation
- States (binning_pkg::sched_state_t): S_WAIT_SOF, S_FILL, S_LAST.
- Internal counters:
  - row_idx, log2K bits: row within the current band.
  - band counter.
  - prev_h, prev_v: coordinates of the last accepted beat.
- SOF beat = valid beat with hcount_in==0 and vcount_in==0.

**S_WAIT_SOF**
- Ignores all beats except SOF.
- On SOF: row_idx=0, band=0, next state S_FILL (S_LAST if K==1 is ever allowed; it is not).

**S_FILL / S_LAST (active)**
- Each valid beat asserts wr_sel_out=1<<row_idx.
- An expected beat is either:
  - same row, hcount_in==prev_h+1; or
  - hcount_in==0 with vcount_in==prev_v+1 and prev_h==HRES-1.
- On row change, row_idx increments mod K.
  - row_idx wrapping to 0 increments band and enters S_FILL.
  - row_idx reaching K-1 enters S_LAST.
- In S_LAST every valid beat asserts acc_en_out.
- emit_out asserts when, in addition, hcount_in[log2K-1:0]==K-1.

**Boundaries and errors**
- Trailing partial columns (HRES mod K) and trailing partial band (VRES mod K) never emit.
- After (HRES-1, VRES-1): frame_done_out pulses and the state becomes S_WAIT_SOF.
- Any unexpected beat: sync_err_out pulses and the state becomes S_WAIT_SOF.
  - If that beat is itself SOF, it restarts at row 0 in S_FILL in the same step. No beat is lost.
- SOF arriving mid-frame is unexpected, so it pulses sync_err_out and restarts.

## Timing
- All outputs registered: exactly 1 cycle after the qualifying input beat. The datapath delays pixel data by one register to align.
- data_valid_in low: wr_sel_out=0, acc_en_out=0, emit_out=0, and state and counters hold. bin_* hold their last value.
- Reset (async assert, sync deassert internally):
  - state S_WAIT_SOF;
  - every output 0;
  - counters 0.
- Reset mid-frame discards the band; the block resumes only at the next SOF.
- emit_out, frame_done_out and sync_err_out are single-cycle pulses.
- emit_out and frame_done_out may coincide on the final beat.

## Configuration
- BINNING_SCHED_STATS_EN defined:
  - adds frame_count_out[15:0], incremented on frame_done;
  - adds err_count_out[15:0], incremented on sync_err;
  - both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

## Structure
- binning_pkg contains:
  - sched_state_t;
  - localparam helpers for log2K;
  - coordinate width functions shared with the binning datapath.
- One sub-module: binning_sync_check. It holds prev_h/prev_v and produces the expected / sof / eof flags combinationally from the current beat.
- The FSM and output registers live in binning_sched.

## Test plan
- Params HRES=8, VRES=8, K=4; one clean frame, no gaps:
  - wr_sel_out cycles 0001→0010→0100→1000 per row;
  - acc_en_out is high for rows 3 and 7 only;
  - emit_out fires 4 times, at hcount 3 and 7 of rows 3 and 7, with bin coords (0,0), (1,0), (0,1), (1,1);
  - frame_done_out pulses once.
- Same frame with valid gaps of 1–5 cycles inserted randomly: identical output sequence, each pulse 1 cycle after its beat.
- HRES=10, VRES=10, K=4: exactly 4 emits; columns 8–9 and rows 8–9 produce none; frame_done_out at (9,9).
- Skip beat hcount 5 in row 2: sync_err_out pulses; no outputs until the next SOF; the following clean frame is correct.
- SOF injected at row 5: sync_err_out pulses and the restart is immediate; the next row yields wr_sel_out=0010.
- rst_n_in low for 1 cycle mid-band: all outputs 0 asynchronously; resume only at next SOF. With BINNING_SCHED_STATS_EN, err_count_out is 0 after reset and 1 after one injected error.
